// File: rtl/hmc_ctrl_pkg.sv
// Shared types and constants for the HMC controller's link-level blocks.
package hmc_ctrl_pkg;

    // Arbiter state: waiting to pick a requester, or holding a packet grant.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Longest legal packet in flits.
    localparam int MAX_PKT_FLITS = 9;

    // Default width of the HMC input-buffer token counter.
    localparam int HMC_TOKEN_W = 10;

    typedef logic [HMC_TOKEN_W-1:0] hmc_tokens_t;

endpackage

// File: rtl/hmc_tx_token_arbiter_rr_pick.sv
// Round-robin priority encoder: the first set request at or after ptr,
// wrapping modulo N, returned both one-hot and as an index.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    int pos;

    // Walk the requests starting at ptr; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!valid && req[pos[PTR_W-1:0]]) begin
                valid                 = 1'b1;
                gnt[pos[PTR_W-1:0]]   = 1'b1;
                idx                   = pos[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/hmc_tx_token_arbiter.sv
// Shares the HMC TX link between requesters: round-robin selection, grant
// held for a whole packet, and each grant gated on input-buffer token credit.
module hmc_tx_token_arbiter
    import hmc_ctrl_pkg::*;
#(
    parameter int NUM_REQ            = 4,
    parameter int LOG_MAX_HMC_TOKENS = HMC_TOKEN_W,
    parameter int LEN_W              = 4
) (
    input  logic                          clk_hmc,
    input  logic                          rst,
    input  logic                          link_up,
    input  logic                          tokens_load,
    input  logic [LOG_MAX_HMC_TOKENS-1:0] tokens_init,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*LEN_W-1:0]      req_len,
    input  logic                          beat_valid,
    input  logic                          beat_last,
    input  logic                          tx_ready,
    input  logic                          tret_valid,
    input  logic [LOG_MAX_HMC_TOKENS-1:0] tret_tokens,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic [LOG_MAX_HMC_TOKENS-1:0] tokens_avail,
    output logic                          token_ovf_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TOK_W = LOG_MAX_HMC_TOKENS;
    localparam logic [TOK_W:0] TOK_MAX = {1'b0, {TOK_W{1'b1}}};

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [TOK_W-1:0]   tokens_q, tokens_d;
    logic               ovf_q, ovf_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] sel_onehot;
    logic [PTR_W-1:0]   sel_idx;
    logic               sel_valid;
    logic [LEN_W-1:0]   sel_len_raw;
    logic [LEN_W-1:0]   sel_len;
    logic               grant_issue;
    logic               pkt_done;
    logic [TOK_W:0]     tok_sum;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .gnt   (sel_onehot),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    // A zero length is illegal; treat it as one flit so credit still moves.
    assign sel_len_raw = req_len[sel_idx*LEN_W +: LEN_W];
    assign sel_len     = (sel_len_raw == '0) ? LEN_W'(1) : sel_len_raw;

    // Credit check uses the registered count, before this cycle's return.
    // The selected requester is never bypassed, so a long packet cannot starve.
    assign grant_issue = (state_q == IDLE) && link_up && sel_valid && !tokens_load
                         && ((TOK_W+1)'(sel_len) <= {1'b0, tokens_q});
    assign pkt_done    = (state_q == GRANT) && beat_valid && tx_ready && beat_last;

    // Arbiter next state: grant on an eligible IDLE cycle, release on the last beat.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (grant_issue) begin
                    state_d  = GRANT;
                    grant_d  = sel_onehot;
                    rr_ptr_d = (sel_idx == PTR_W'(NUM_REQ-1)) ? '0 : sel_idx + 1'b1;
                end
            end
            GRANT: begin
                if (pkt_done) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Token credit: add returns, debit grants, saturate with a sticky error;
    // a load replaces the count outright and discards that cycle's return.
    always_comb begin
        tokens_d = tokens_q;
        ovf_d    = ovf_q;
        tok_sum  = {1'b0, tokens_q}
                   + (tret_valid  ? {1'b0, tret_tokens}  : '0)
                   - (grant_issue ? (TOK_W+1)'(sel_len) : '0);
        if (tokens_load) begin
            tokens_d = tokens_init;
        end else if (tok_sum > TOK_MAX) begin
            tokens_d = '1;
            ovf_d    = 1'b1;
        end else begin
            tokens_d = tok_sum[TOK_W-1:0];
        end
    end

    // State registers with synchronous reset; reset mid-packet drops everything.
    always_ff @(posedge clk_hmc) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            tokens_q <= '0;
            ovf_q    <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            tokens_q <= tokens_d;
            ovf_q    <= ovf_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant         = grant_q;
    assign busy          = (state_q == GRANT);
    assign tokens_avail  = tokens_q;
    assign token_ovf_err = ovf_q;

    // Granted packet lengths must be legal.
    a_len_legal : assert property (@(posedge clk_hmc) disable iff (rst)
        grant_issue |-> (sel_len_raw != '0) && (int'(sel_len_raw) <= MAX_PKT_FLITS));

endmodule

// File: tb/tb_hmc_tx_token_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_hmc_tx_token_arbiter;

    localparam int N    = 4;
    localparam int TW   = 10;
    localparam int LW   = 4;
    localparam int MAXT = (1 << TW) - 1;

    logic            clk_hmc = 1'b0;
    logic            rst;
    logic            link_up;
    logic            tokens_load;
    logic [TW-1:0]   tokens_init;
    logic [N-1:0]    req_valid;
    logic [N*LW-1:0] req_len;
    logic            beat_valid;
    logic            beat_last;
    logic            tx_ready;
    logic            tret_valid;
    logic [TW-1:0]   tret_tokens;
    logic [N-1:0]    grant;
    logic            busy;
    logic [TW-1:0]   tokens_avail;
    logic            token_ovf_err;

    hmc_tx_token_arbiter #(
        .NUM_REQ            (N),
        .LOG_MAX_HMC_TOKENS (TW),
        .LEN_W              (LW)
    ) dut (
        .clk_hmc       (clk_hmc),
        .rst           (rst),
        .link_up       (link_up),
        .tokens_load   (tokens_load),
        .tokens_init   (tokens_init),
        .req_valid     (req_valid),
        .req_len       (req_len),
        .beat_valid    (beat_valid),
        .beat_last     (beat_last),
        .tx_ready      (tx_ready),
        .tret_valid    (tret_valid),
        .tret_tokens   (tret_tokens),
        .grant         (grant),
        .busy          (busy),
        .tokens_avail  (tokens_avail),
        .token_ovf_err (token_ovf_err)
    );

    always #5 clk_hmc = ~clk_hmc;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: which requester holds the link, credit as a plain int.
    int m_tok;
    int m_rr;
    int m_gidx;
    bit m_inflight;
    bit m_ovf;
    bit chk_en = 1'b0;

    task automatic model_step();
        int sel;
        int len;
        bit issue;
        int nxt;
        if (rst) begin
            m_tok = 0; m_rr = 0; m_gidx = 0; m_inflight = 0; m_ovf = 0;
            return;
        end
        sel   = -1;
        len   = 0;
        issue = 0;
        if (!m_inflight) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_rr + k) % N;
                if (sel < 0 && req_valid[i]) sel = i;
            end
            if (sel >= 0) begin
                len = int'(req_len[sel*LW +: LW]);
                if (len == 0) len = 1;
                issue = link_up && !tokens_load && (len <= m_tok);
            end
        end else if (beat_valid && tx_ready && beat_last) begin
            m_inflight = 0;
        end
        if (tokens_load) begin
            m_tok = int'(tokens_init);
        end else begin
            nxt = m_tok + (tret_valid ? int'(tret_tokens) : 0) - (issue ? len : 0);
            if (nxt > MAXT) begin
                nxt   = MAXT;
                m_ovf = 1;
            end
            m_tok = nxt;
        end
        if (issue) begin
            m_inflight = 1;
            m_gidx     = sel;
            m_rr       = (sel + 1) % N;
        end
    endtask

    // Every cycle: outputs must match the model.
    always @(negedge clk_hmc) begin
        if (chk_en) begin
            check("model_grant",  32'(grant),         m_inflight ? (32'd1 << m_gidx) : 32'd0);
            check("model_busy",   32'(busy),          32'(m_inflight));
            check("model_tokens", 32'(tokens_avail),  32'(m_tok));
            check("model_ovf",    32'(token_ovf_err), 32'(m_ovf));
        end
    end

    task automatic cycle();
        @(posedge clk_hmc);
        model_step();
        @(negedge clk_hmc);
    endtask

    task automatic clear_inputs();
        tokens_load = 0; tokens_init = '0; req_valid = '0;
        beat_valid = 0; beat_last = 0; tx_ready = 0;
        tret_valid = 0; tret_tokens = '0; link_up = 1;
    endtask

    task automatic do_reset();
        rst = 1;
        cycle();
        rst = 0;
        clear_inputs();
    endtask

    task automatic load(input int v);
        tokens_load = 1;
        tokens_init = TW'(v);
        cycle();
        tokens_load = 0;
    endtask

    task automatic set_len(input int i, input int v);
        req_len[i*LW +: LW] = LW'(v);
    endtask

    task automatic finish_pkt();
        beat_valid = 1; tx_ready = 1; beat_last = 1;
        cycle();
        beat_valid = 0; tx_ready = 0; beat_last = 0;
    endtask

    logic [N-1:0] rr_exp [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                 4'b0000, 4'b1000, 4'b0000, 4'b0001};

    initial begin
        req_len = '0;
        clear_inputs();
        rst = 1;
        cycle();
        chk_en = 1;
        cycle();
        check("reset_grant",  32'(grant),         0);
        check("reset_busy",   32'(busy),          0);
        check("reset_tokens", 32'(tokens_avail),  0);
        check("reset_ovf",    32'(token_ovf_err), 0);
        rst = 0;

        // Basic grant and two-beat packet.
        load(20);
        check("basic_load", 32'(tokens_avail), 20);
        set_len(0, 5);
        req_valid = 4'b0001;
        cycle();
        check("basic_grant",  32'(grant),        4'b0001);
        check("basic_tokens", 32'(tokens_avail), 15);
        req_valid = '0;
        beat_valid = 1; tx_ready = 1; beat_last = 0;
        cycle();
        check("basic_hold", 32'(grant), 4'b0001);
        beat_last = 1;
        cycle();
        check("basic_release", 32'(grant), 0);
        check("basic_idle",    32'(busy),  0);
        beat_valid = 0; tx_ready = 0; beat_last = 0;

        // Round-robin order with an idle cycle between packets.
        do_reset();
        load(100);
        for (int i = 0; i < N; i++) set_len(i, 1);
        req_valid = 4'b1111;
        beat_valid = 1; tx_ready = 1; beat_last = 1;
        for (int i = 0; i < 9; i++) begin
            cycle();
            check("rr_order", 32'(grant), 32'(rr_exp[i]));
        end
        req_valid = '0;
        cycle();
        beat_valid = 0; tx_ready = 0; beat_last = 0;

        // Credit blocking: req0 needs 5, only 3 available; req1 must wait.
        do_reset();
        load(3);
        set_len(0, 5);
        set_len(1, 1);
        req_valid = 4'b0011;
        repeat (3) begin
            cycle();
            check("block_nogrant", 32'(grant), 0);
        end
        check("block_tokens", 32'(tokens_avail), 3);
        tret_valid = 1; tret_tokens = 2;
        cycle();
        tret_valid = 0;
        check("block_tret_nogrant", 32'(grant),        0);
        check("block_tret_tokens",  32'(tokens_avail), 5);
        cycle();
        check("block_grant0", 32'(grant),        4'b0001);
        check("block_zero",   32'(tokens_avail), 0);
        req_valid = '0;
        finish_pkt();

        // Debit and return together, then load overriding a return and a grant.
        do_reset();
        load(8);
        set_len(0, 4);
        req_valid = 4'b0001;
        tret_valid = 1; tret_tokens = 6;
        cycle();
        tret_valid = 0;
        req_valid = '0;
        check("simul_tokens", 32'(tokens_avail), 10);
        check("simul_grant",  32'(grant),        4'b0001);
        finish_pkt();
        set_len(0, 1);
        req_valid = 4'b0001;
        tokens_load = 1; tokens_init = 7;
        tret_valid = 1; tret_tokens = 5;
        cycle();
        tokens_load = 0; tret_valid = 0;
        check("load_tokens",  32'(tokens_avail), 7);
        check("load_nogrant", 32'(grant),        0);
        cycle();
        check("after_load_grant",  32'(grant),        4'b0001);
        check("after_load_tokens", 32'(tokens_avail), 6);
        req_valid = '0;
        finish_pkt();

        // Saturation with a sticky error that only reset clears.
        do_reset();
        load(1020);
        tret_valid = 1; tret_tokens = 10;
        cycle();
        tret_valid = 0;
        check("sat_tokens", 32'(tokens_avail),  MAXT);
        check("sat_ovf",    32'(token_ovf_err), 1);
        repeat (3) cycle();
        load(5);
        check("sat_sticky",      32'(token_ovf_err), 1);
        check("sat_load_tokens", 32'(tokens_avail),  5);
        do_reset();
        check("sat_cleared", 32'(token_ovf_err), 0);

        // Reset in the middle of a packet, then arbitration restarts at req0.
        load(50);
        set_len(2, 3);
        req_valid = 4'b0100;
        cycle();
        check("midrst_grant2", 32'(grant), 4'b0100);
        req_valid = '0;
        rst = 1;
        cycle();
        rst = 0;
        check("midrst_grant",  32'(grant),        0);
        check("midrst_busy",   32'(busy),         0);
        check("midrst_tokens", 32'(tokens_avail), 0);
        load(50);
        for (int i = 0; i < N; i++) set_len(i, 1);
        req_valid = 4'b1111;
        cycle();
        check("midrst_restart", 32'(grant), 4'b0001);
        req_valid = '0;
        finish_pkt();

        // Link drops during a packet: it completes, nothing new is granted.
        set_len(1, 2);
        req_valid = 4'b0010;
        cycle();
        check("link_grant1", 32'(grant), 4'b0010);
        link_up = 0;
        req_valid = 4'b1111;
        cycle();
        check("link_hold", 32'(grant), 4'b0010);
        finish_pkt();
        cycle();
        check("link_down_nogrant", 32'(grant), 0);
        link_up = 1;
        req_valid = '0;
        cycle();

        // Randomized traffic against the model.
        repeat (3000) begin
            rst         = ($urandom_range(0, 499) == 0);
            link_up     = ($urandom_range(0, 19) != 0);
            tokens_load = ($urandom_range(0, 99) == 0);
            tokens_init = TW'($urandom_range(0, MAXT));
            tret_valid  = ($urandom_range(0, 3) == 0);
            tret_tokens = ($urandom_range(0, 29) == 0) ? TW'($urandom_range(0, MAXT))
                                                       : TW'($urandom_range(0, 15));
            req_valid   = N'($urandom);
            for (int i = 0; i < N; i++) set_len(i, $urandom_range(1, 9));
            beat_valid  = $urandom_range(0, 1);
            tx_ready    = $urandom_range(0, 1);
            beat_last   = ($urandom_range(0, 2) == 0);
            cycle();
        end
        rst = 0;
        clear_inputs();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hmc_tx_token_arbiter.md
Name: hmc_tx_token_arbiter

Overview:
- Shares the single HMC TX link between NUM_REQ packet requesters (AXI request path, register-file-generated flow packets, etc.).
- Picks one requester by round-robin and holds that grant for the whole packet.
- Gates each grant on HMC input-buffer token credit: a packet's length in flits is debited at grant time.
- Credits come from token returns decoded by the RX path, and the initial credit is loaded from the register file.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LOG_MAX_HMC_TOKENS, 10, token counter width; maximum credit is 2^LOG_MAX_HMC_TOKENS-1.
- LEN_W, 4, packet length field width in flits; legal lengths are 1..9.

Ports:
- clk_hmc  in  1  link clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- link_up  in  1  link trained; no grants while low.
- tokens_load  in  1  one-cycle pulse; loads tokens_init into the counter.
- tokens_init  in  LOG_MAX_HMC_TOKENS  initial credit from the RF.
- req_valid  in  NUM_REQ  requester i has a packet pending.
- req_len  in  NUM_REQ*LEN_W  packet length of requester i at slice [i*LEN_W +: LEN_W].
- beat_valid  in  1  granted requester presents a TX beat.
- beat_last  in  1  the current beat ends the packet.
- tx_ready  in  1  TX datapath accepts the beat.
- tret_valid  in  1  token return present this cycle.
- tret_tokens  in  LOG_MAX_HMC_TOKENS  number of tokens returned.
- grant  out  NUM_REQ  one-hot grant, registered.
- busy  out  1  a packet is in flight.
- tokens_avail  out  LOG_MAX_HMC_TOKENS  current credit.
- token_ovf_err  out  1  sticky; set on credit saturation.

Behaviour:
- Reset: grant=0, busy=0, tokens_avail=0, token_ovf_err=0, rr_ptr=0, state=IDLE.
- Reset mid-packet aborts the packet immediately and discards all state.
- Selection (combinational, evaluated in IDLE):
  - sel = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Strict round-robin with no skipping: if sel lacks credit, the arbiter waits for credit. Lower-priority requesters do not bypass it, so a long packet cannot be starved.
- Eligibility: link_up & any req_valid & (req_len[sel] <= tokens_avail) & !tokens_load.
  - The comparison uses the registered count, i.e. the value before this cycle's return is added.
- IDLE -> GRANT:
  - Happens on the eligible cycle. grant[sel] and busy assert the next cycle (one-cycle grant latency).
  - tokens_avail is debited by req_len[sel] on that same edge.
  - rr_ptr <= sel+1 mod NUM_REQ.
- GRANT -> IDLE:
  - Happens on the cycle with beat_valid & tx_ready & beat_last. grant and busy deassert the next cycle.
  - A new grant cannot be issued on that same edge, so packets are separated by at least one idle cycle.
- GRANT while link_up falls: the packet completes normally; no new grants are issued afterwards.
- req_valid and req_len are sampled only at grant time; changes during GRANT are ignored.
- Token update, applied every cycle:
  - next = tokens_avail + (tret_valid ? tret_tokens : 0) - (grant_issue ? len : 0).
  - Computed at LOG_MAX_HMC_TOKENS+1 bits.
  - If next > 2^LOG_MAX_HMC_TOKENS-1: saturate at the maximum and set token_ovf_err. The error clears only on rst.
  - A return and a debit in the same cycle both apply.
  - tokens_load overrides everything: count = tokens_init, any return that cycle is discarded, and no grant is issued that cycle.
- Zero-length requests (req_len=0) are illegal; an assertion flags them in simulation. The RTL treats length 0 as 1.

Decomposition:
- Shared package hmc_ctrl_pkg holds:
  - the arbiter state enum {IDLE, GRANT};
  - the MAX_PKT_FLITS=9 constant;
  - the token-width typedef derived from LOG_MAX_HMC_TOKENS.
- One natural sub-module, rr_pick: a parameterised round-robin priority encoder (req vector + pointer -> one-hot + index). It is reusable by the RX response dispatcher.

Test Plan:
- Basic grant: load 20 tokens; req_valid=0001, len=5.
  - grant=0001 appears 1 cycle later; tokens_avail=15.
  - A 2-beat packet with last on beat 2 → grant drops 1 cycle after that beat.
- Round-robin: 100 tokens; all 4 requesters valid with len=1, single-beat packets.
  - Grant order is 0,1,2,3,0; each packet is separated by 1 idle cycle.
- Credit blocking: 3 tokens; req0 len=5, req1 len=1.
  - No grant is issued; req1 is not bypassed.
  - tret 2 tokens → grant0 the next cycle; tokens_avail=0.
- Simultaneous events: 8 tokens; grant len=4 in the same cycle as tret 6 → tokens_avail=10.
  - tokens_load=7 together with tret 5 → tokens_avail=7 and no grant that cycle.
- Saturation: LOG_MAX_HMC_TOKENS=10; load 1020, then tret 10 → tokens_avail=1023 and token_ovf_err=1, which stays set until rst.
- Reset mid-packet: assert rst during GRANT of req2.
  - Next cycle: grant=0, busy=0, tokens_avail=0.
  - After reload, arbitration restarts at req0.
